// File: rtl/i2c_slave_target_if.sv
// Bus-side bundle of the I2C target: the raw SCL/SDA inputs, the open-drain
// SDA pull-down, the register-write strobe and the busy flag.
interface i2c_slave_target_if #(
    parameter int NO_OF_REG = 4
);
    localparam int PW = $clog2(NO_OF_REG);

    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          reg_wr_en;
    logic [PW-1:0] reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic          busy;

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe,
        output reg_wr_en,
        output reg_wr_addr,
        output reg_wr_data,
        output busy
    );

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe,
        input  reg_wr_en,
        input  reg_wr_addr,
        input  reg_wr_data,
        input  busy
    );
endinterface

// File: rtl/i2c_slave_target.sv
// 7-bit-addressed I2C target with an oversampled bus front end and a small
// register file behind an auto-incrementing pointer.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int         NO_OF_REG     = 4,
    parameter int         DATA_WIDTH    = 8
) (
    input logic              pclk,
    input logic              areset,
    i2c_slave_target_if.slave bus
);
    localparam int PW = $clog2(NO_OF_REG);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        WAIT_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  rw_q, rw_d;
    logic                  phase_q, phase_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic [PW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] regs [NO_OF_REG];

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [DATA_WIDTH-1:0] rx_byte, rd_byte;

    // Synchronizers idle high so reset release never looks like a START.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // The register file commits on the cycle the write strobe is visible.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < NO_OF_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_q) begin
            regs[wr_addr_q] <= wr_data_q;
        end
    end

    // phase_q marks the second half of a two-edge step: in an ACK state it
    // means SDA is already held low, in RACK that the master ACKed.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rx_byte   = {shift_q[DATA_WIDTH-2:0], sda_s2};
        rd_byte   = regs[ptr_q];

        if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[DATA_WIDTH-1:1] == SLAVE_ADDRESS &&
                                rx_byte[DATA_WIDTH-1:1] != 7'd0) begin
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                REG: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d   = rx_byte[PW-1:0];
                            state_d = REG_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            ptr_d     = ptr_q + 1'b1;
                            state_d   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_d  = rd_byte;
                                sda_oe_d = ~rd_byte[DATA_WIDTH-1];
                                state_d  = RDATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = (state_q == ADDR_ACK) ? REG : WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + 1'b1;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            state_d   = RACK;
                        end else begin
                            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            sda_oe_d  = ~shift_q[DATA_WIDTH-2];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_s2) begin
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[DATA_WIDTH-1];
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                    end
                end
                IDLE, WAIT_STOP: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.sda_oe      = sda_oe_q;
    assign bus.busy        = busy_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q[7:0];
endmodule
